state_reg_bank: RTL
===================

# state_reg_bank

Parametrised successor to the ASCON state register: an N-lane state register with per-lane masked load, XOR-absorb and clear operations, per-lane dirty tracking and a saturating update counter. It sits between the permutation datapath and the FSM, so key/data/domain-separation XORs (x0 absorb, x3/x4 key add, x1/x2 finalisation, x4 bit-0 domain flag) are applied inside the register instead of by external muxes.

## Interface
- NB_LANES, 5, number of state lanes
- LANE_W, 64, bits per lane
- CNT_W, 4, width of update counter
- clock_i  in  1  rising-edge clock
- reset_i  in  1  asynchronous, active-high reset
- en_i  in  1  commit strobe; op_i sampled only when high
- op_i  in  2  operation (OP_HOLD=0, OP_LOAD=1, OP_XOR=2, OP_CLEAR=3)
- lane_mask_i  in  NB_LANES  bit k selects lane k
- d_i  in  NB_LANES×LANE_W  load operand, lane k at bits [k*LANE_W +: LANE_W]
- x_i  in  NB_LANES×LANE_W  XOR operand, same lane layout
- cnt_clr_i  in  1  synchronous counter clear
- q_o  out  NB_LANES×LANE_W  current state
- dirty_o  out  NB_LANES  lane written since its last clear
- upd_cnt_o  out  CNT_W  committed updates, saturating
- upd_o  out  1  one-cycle pulse, previous cycle committed an update

## Operation
- A commit is en_i=1 with op_i≠OP_HOLD and lane_mask_i≠0.
- Per lane k at the clock edge with en_i=1 and lane_mask_i[k]=1:
  - OP_LOAD: q[k] ← d_i[k]; dirty[k] ← 1
  - OP_XOR: q[k] ← q[k] ^ x_i[k]; dirty[k] ← 1
  - OP_CLEAR: q[k] ← 0; dirty[k] ← 0
  - OP_HOLD: no change
- Unmasked lanes, and all lanes when en_i=0, hold value and dirty bit.
- XOR uses the pre-edge register value, never d_i.
- upd_cnt: cnt_clr_i=1 → 0, regardless of en_i (clear wins over simultaneous commit); else commit → +1, saturating at 2^CNT_W−1 with no wrap; else hold.
- upd_o ← commit, registered, independent of cnt_clr_i and saturation.
- With NB_LANES=5 and LANE_W=64, q_o is bit-compatible with type_state (lane 0 = x0).

## Timing
- Reset (async assert, immediate): q_o=0, dirty_o=0, upd_cnt_o=0, upd_o=0. Deassertion is taken synchronously by the surrounding reset synchroniser; the first edge after release may commit.
- Reset mid-operation discards any in-flight commit; no partial lane update.
- Load/XOR/clear latency: 1 cycle. Values are visible on q_o right after the sampling edge.
- Back-to-back commits every cycle are supported. Each XOR compounds on the previous result.
- upd_o is high for exactly the cycle after each commit. N consecutive commits give N consecutive high cycles.
- Outputs are registers only. There is no combinational path from inputs to outputs.

## Structure
- ascon_pack gains:
  - type_reg_op enum {OP_HOLD, OP_LOAD, OP_XOR, OP_CLEAR}, 2 bits
  - NB_LANES_C=5 and LANE_W_C=64 as default constants
- Ports use packed 2-D logic arrays sized by parameters, because type_state is fixed-size.
- One sub-module, lane_reg: a single LANE_W lane with mask/op/dirty logic, instantiated NB_LANES times by generate.
- Counter and upd_o pulse live in the top.

## Test plan
- Reset: drive q via LOAD to all-ones, assert reset_i asynchronously mid-cycle → q_o, dirty_o, upd_cnt_o, upd_o = 0 immediately, before the next edge.
- Masked load: mask=5'b00001, d lane0=0x80400C0600000000, other lanes 0xFF..F → only lane0 changes, dirty_o=5'b00001, upd_cnt_o=1, upd_o pulses one cycle.
- XOR compounding: lane4=0x0, two consecutive XOR commits with x lane4=0x1 then 0x3, mask=5'b10000 → lane4=0x1, then 0x2. Lanes 0–3 unchanged.
- Clear and dirty: LOAD all lanes, then CLEAR mask=5'b00110 → lanes 1,2 = 0, dirty_o=5'b11001. Then en_i=0 with op=LOAD → no change, no upd_o.
- Counter: 20 commits with CNT_W=4 → upd_cnt_o saturates at 15. Commit and cnt_clr_i in the same cycle → 0, with upd_o still pulsing.
- Null commits: en_i=1, op=LOAD, mask=0, and en_i=1, op=HOLD, mask=all → no state change, counter unchanged, upd_o stays low.

Source files
------------

// File: rtl/state_reg_bank_pkg.sv
// Shared operation encoding and default geometry for the multi-lane state register.
package state_reg_bank_pkg;

   typedef enum logic [1:0] {
      OP_HOLD  = 2'd0,
      OP_LOAD  = 2'd1,
      OP_XOR   = 2'd2,
      OP_CLEAR = 2'd3
   } type_reg_op;

   localparam int NB_LANES_C = 5;
   localparam int LANE_W_C   = 64;

   // A commit needs a strobe, a real operation and at least one selected lane.
   function automatic logic is_commit(input logic en, input logic [1:0] op, input logic any_lane);
      return en && (type_reg_op'(op) != OP_HOLD) && any_lane;
   endfunction

endpackage

// File: rtl/state_reg_bank_lane_reg.sv
// One state lane: load, XOR-absorb or clear when selected, with its dirty flag.
module state_reg_bank_lane_reg
   import state_reg_bank_pkg::*;
#(
   parameter int LANE_W = LANE_W_C
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              we_i,
   input  logic [1:0]        op_i,
   input  logic [LANE_W-1:0] d_i,
   input  logic [LANE_W-1:0] x_i,
   output logic [LANE_W-1:0] q_o,
   output logic              dirty_o
);

   logic [LANE_W-1:0] q_q, q_d;
   logic              dirty_q, dirty_d;

   always_comb begin
      q_d     = q_q;
      dirty_d = dirty_q;
      if (we_i) begin
         unique case (type_reg_op'(op_i))
            OP_LOAD: begin
               q_d     = d_i;
               dirty_d = 1'b1;
            end
            OP_XOR: begin
               q_d     = q_q ^ x_i;
               dirty_d = 1'b1;
            end
            OP_CLEAR: begin
               q_d     = '0;
               dirty_d = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         q_q     <= '0;
         dirty_q <= 1'b0;
      end else begin
         q_q     <= q_d;
         dirty_q <= dirty_d;
      end
   end

   assign q_o     = q_q;
   assign dirty_o = dirty_q;

endmodule

// File: rtl/state_reg_bank.sv
// N-lane state register with per-lane masked ops, saturating update counter and update pulse.
module state_reg_bank
   import state_reg_bank_pkg::*;
#(
   parameter int NB_LANES = NB_LANES_C,
   parameter int LANE_W   = LANE_W_C,
   parameter int CNT_W    = 4
) (
   input  logic                             clock_i,
   input  logic                             reset_i,
   input  logic                             en_i,
   input  logic [1:0]                       op_i,
   input  logic [NB_LANES-1:0]              lane_mask_i,
   input  logic [NB_LANES-1:0][LANE_W-1:0]  d_i,
   input  logic [NB_LANES-1:0][LANE_W-1:0]  x_i,
   input  logic                             cnt_clr_i,
   output logic [NB_LANES-1:0][LANE_W-1:0]  q_o,
   output logic [NB_LANES-1:0]              dirty_o,
   output logic [CNT_W-1:0]                 upd_cnt_o,
   output logic                             upd_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             commit;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             upd_q;

   assign commit = is_commit(en_i, op_i, |lane_mask_i);

   generate
      for (genvar gi = 0; gi < NB_LANES; gi++) begin : g_lane
         state_reg_bank_lane_reg #(.LANE_W(LANE_W)) u_lane (
            .clock_i (clock_i),
            .reset_i (reset_i),
            .we_i    (en_i && lane_mask_i[gi]),
            .op_i    (op_i),
            .d_i     (d_i[gi]),
            .x_i     (x_i[gi]),
            .q_o     (q_o[gi]),
            .dirty_o (dirty_o[gi])
         );
      end
   endgenerate

   // Clear takes priority over a commit in the same cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr_i) begin
         cnt_d = '0;
      end else if (commit && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= '0;
         upd_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         upd_q <= commit;
      end
   end

   assign upd_cnt_o = cnt_q;
   assign upd_o     = upd_q;

endmodule
